// File: rtl/prog_loader.sv
// Byte-stream program loader: frames bytes into 16-bit RAM words and holds the CPU in reset while loading.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [15:0]       ram_w_data,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [2:0] {StIdle, StHdr, StHi, StLo, StWrite, StDone, StErr} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, pc_q, pc_d;
  logic [7:0]          hi_q, hi_d, lo_q, lo_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d, cpu_rst_n_q, cpu_rst_n_d;
  logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  assign in_ready = (state_q == StHdr) || (state_q == StHi) || (state_q == StLo);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (load_req) begin
          state_d = StHdr;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StHdr: begin
        if (xfer) begin
          ptr_d = ADDR_W'(in_byte);
          pc_d  = ADDR_W'(in_byte);
`ifdef LOADER_CHECKSUM_EN
          sum_d   = in_byte;
          state_d = in_last ? StErr : StHi;
`else
          state_d = in_last ? StDone : StHi;
`endif
        end
      end
      StHi: begin
        if (xfer) begin
          hi_d = in_byte;
`ifdef LOADER_CHECKSUM_EN
          // A last byte in high position is the checksum, not data.
          if (in_last) state_d = (in_byte == sum_q) ? StDone : StErr;
          else begin
            sum_d   = sum_q + in_byte;
            state_d = StLo;
          end
`else
          state_d = in_last ? StErr : StLo;
`endif
        end
      end
      StLo: begin
        if (xfer) begin
          lo_d   = in_byte;
          last_d = in_last;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_byte;
          state_d = in_last ? StErr : StWrite;
`else
          state_d = StWrite;
`endif
        end
      end
      StWrite: begin
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        state_d = last_q ? StDone : StHi;
      end
      default: state_d = StIdle;
    endcase

    // Registered status outputs are decoded from the next state.
    we_d        = (state_d == StWrite);
    busy_d      = (state_d == StHdr) || (state_d == StHi) || (state_d == StLo) ||
                  (state_d == StWrite);
    done_d      = (state_d == StDone);
    error_d     = (state_d == StErr);
    cpu_rst_n_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      pc_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pc_q        <= pc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

  assign ram_w_en   = we_q;
  assign ram_w_addr = ptr_q;
  assign ram_w_data = {hi_q, lo_q};
  assign cpu_rst_n  = cpu_rst_n_q;
  assign start_pc   = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = cnt_q;

endmodule
